multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the MiniRiscV core. It sequences instruction fetch, decode, ALU execute, data-memory access and register write-back, and it drives the ALU's `ALUOp`/`ALUSrc`. It also resolves branches from the ALU's combinational `doBranch`, handshakes with instruction and data memories, and counts retired instructions. It sits between the memories, register file, PC register and the registered ALU.

---
 rtl/ctrl_pkg.sv | 56 +++++
 rtl/ctrl_decode.sv | 27 ++
 rtl/multicycle_ctrl.sv | 156 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the MiniRiscV multi-cycle controller: opcodes, FSM
// states, instruction classes and the ALU / write-back / PC-select codes.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_R,
    C_I,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_ILLEGAL
  } iclass_e;

  localparam logic [1:0] ALU_OP_LDST   = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_ARITH  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic PC_SRC_PLUS4 = 1'b0;
  localparam logic PC_SRC_IMM   = 1'b1;

  // Returns {alu_op, alu_src} for a latched instruction class.
  function automatic logic [2:0] alu_ctrl(iclass_e c);
    logic [2:0] r;
    case (c)
      C_R:      r = {ALU_OP_ARITH, 1'b0};
      C_I:      r = {ALU_OP_ARITH, 1'b1};
      C_LOAD,
      C_STORE:  r = {ALU_OP_LDST, 1'b1};
      C_BRANCH: r = {ALU_OP_BRANCH, 1'b0};
      default:  r = {ALU_OP_LDST, 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode -> instruction-class mapping; unknown opcodes map to
// C_ILLEGAL.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] cls
);

  iclass_e cls_e;

  always_comb begin
    cls_e = C_ILLEGAL;
    case (opcode)
      OP_R:      cls_e = C_R;
      OP_I:      cls_e = C_I;
      OP_LOAD:   cls_e = C_LOAD;
      OP_STORE:  cls_e = C_STORE;
      OP_BRANCH: cls_e = C_BRANCH;
      OP_JAL:    cls_e = C_JAL;
      default:   cls_e = C_ILLEGAL;
    endcase
  end

  assign cls = cls_e;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing, ALU control,
// branch resolution, memory handshakes and retired-instruction counting.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  input  logic [6:0]           opcode,
  input  logic                 do_branch,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic [1:0]           alu_op,
  output logic                 alu_src,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 retire,
  output logic                 trap,
  output logic [INSTRET_W-1:0] instret
);

  state_e                 state_q, state_d;
  iclass_e                cls_q, cls_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   quiet_q, quiet_d;
  logic                   fetch_busy_q, fetch_busy_d;
  logic [2:0]             dec_cls_raw;
  iclass_e                dec_cls;
  logic                   active;

  ctrl_decode u_decode (
    .opcode (opcode),
    .cls    (dec_cls_raw)
  );

  assign dec_cls = iclass_e'(dec_cls_raw);

  // quiet_q keeps every output low for the first cycle after reset.
  assign active = rst && !quiet_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      cls_q        <= C_ILLEGAL;
      instret_q    <= '0;
      quiet_q      <= 1'b1;
      fetch_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      instret_q    <= instret_d;
      quiet_q      <= quiet_d;
      fetch_busy_q <= fetch_busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    quiet_d      = 1'b0;
    fetch_busy_d = 1'b0;
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    alu_op       = ALU_OP_LDST;
    alu_src      = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_PLUS4;
    retire       = 1'b0;
    trap         = 1'b0;

    if (active) begin
      case (state_q)
        S_FETCH: begin
          // halt only blocks a new request; an outstanding one runs to ready.
          if (!halt || fetch_busy_q) begin
            imem_req = 1'b1;
            if (imem_ready) begin
              ir_write = 1'b1;
              state_d  = S_DECODE;
            end else begin
              fetch_busy_d = 1'b1;
            end
          end
        end
        S_DECODE: begin
          cls_d   = dec_cls;
          state_d = (dec_cls == C_ILLEGAL) ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          {alu_op, alu_src} = alu_ctrl(cls_q);
          case (cls_q)
            C_BRANCH: begin
              pc_write = 1'b1;
              pc_src   = do_branch;
              retire   = 1'b1;
              state_d  = S_FETCH;
            end
            C_JAL: begin
              reg_write = 1'b1;
              wb_sel    = WB_PC4;
              pc_write  = 1'b1;
              pc_src    = PC_SRC_IMM;
              retire    = 1'b1;
              state_d   = S_FETCH;
            end
            C_LOAD, C_STORE: state_d = S_MEM;
            default:         state_d = S_WB;
          endcase
        end
        S_MEM: begin
          {alu_op, alu_src} = alu_ctrl(cls_q);
          dmem_req = 1'b1;
          dmem_we  = (cls_q == C_STORE);
          if (dmem_ready) begin
            if (cls_q == C_STORE) begin
              pc_write = 1'b1;
              retire   = 1'b1;
              state_d  = S_FETCH;
            end else begin
              state_d  = S_WB;
            end
          end
        end
        S_WB: begin
          {alu_op, alu_src} = alu_ctrl(cls_q);
          reg_write = 1'b1;
          wb_sel    = (cls_q == C_LOAD) ? WB_MEM : WB_ALU;
          pc_write  = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        S_TRAP: begin
          trap = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end

    instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, retire};
  end

  assign instret = rst ? instret_q : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: per-instruction expected cycle traces are built from the
// class rules and replayed against the DUT one cycle at a time.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       pc_write;
    logic       pc_src;
    logic       retire;
    logic       trap;
    logic [3:0] instret;
  } outv_t;

  typedef struct {
    logic       rst;
    logic       halt;
    logic [6:0] opcode;
    logic       do_branch;
    logic       imem_ready;
    logic       dmem_ready;
    outv_t      exp;
  } cycle_t;

  logic       clk = 1'b0;
  logic       rst, halt, do_branch, imem_ready, dmem_ready;
  logic [6:0] opcode;
  logic       imem_req, ir_write, alu_src, dmem_req, dmem_we, reg_write;
  logic       pc_write, pc_src, retire, trap;
  logic [1:0] alu_op, wb_sel;
  logic [3:0] instret;

  cycle_t q[$];
  int     cnt    = 0;
  int     budget = -1;
  int     checks = 0;
  int     fails  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.INSTRET_W(4)) dut (
    .clk(clk), .rst(rst), .halt(halt), .opcode(opcode), .do_branch(do_branch),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_write(ir_write), .alu_op(alu_op), .alu_src(alu_src), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write),
    .pc_src(pc_src), .retire(retire), .trap(trap), .instret(instret)
  );

  function automatic cycle_t blank();
    cycle_t c;
    c.rst        = 1'b1;
    c.halt       = 1'($urandom);
    c.opcode     = 7'($urandom);
    c.do_branch  = 1'($urandom);
    c.imem_ready = 1'($urandom);
    c.dmem_ready = 1'($urandom);
    c.exp        = '0;
    c.exp.instret = 4'(cnt);
    return c;
  endfunction

  function automatic void push(cycle_t c);
    if (budget != 0) begin
      q.push_back(c);
      if (budget > 0) budget--;
    end
  endfunction

  function automatic void gen_reset();
    cycle_t c;
    c = blank();
    c.rst = 1'b0;
    c.exp = '0;
    push(c);
    cnt = 0;
    c = blank();
    push(c);
  endfunction

  function automatic void gen_trap(int n);
    cycle_t c;
    for (int i = 0; i < n; i++) begin
      c = blank();
      c.exp.trap = 1'b1;
      push(c);
    end
  endfunction

  // Pushes the cycle trace of one instruction; returns its length excluding
  // halt cycles. hw: halt cycles before fetch, iw/dw: memory wait cycles.
  function automatic int gen(logic [6:0] op, int hw, int iw, int dw, logic br);
    cycle_t     c;
    int         n = 0;
    logic [1:0] aop;
    logic       asrc;
    for (int h = 0; h < hw; h++) begin
      c = blank();
      c.halt = 1'b1;
      push(c);
    end
    for (int w = 0; w < iw; w++) begin
      c = blank();
      if (w == 0) c.halt = 1'b0;
      c.imem_ready = 1'b0;
      c.exp.imem_req = 1'b1;
      push(c); n++;
    end
    c = blank();
    if (iw == 0) c.halt = 1'b0;
    c.imem_ready = 1'b1;
    c.exp.imem_req = 1'b1;
    c.exp.ir_write = 1'b1;
    push(c); n++;
    c = blank();
    c.opcode = op;
    push(c); n++;
    case (op)
      OP_R:                   begin aop = 2'b10; asrc = 1'b0; end
      OP_I:                   begin aop = 2'b10; asrc = 1'b1; end
      OP_LOAD, OP_STORE:      begin aop = 2'b00; asrc = 1'b1; end
      OP_BRANCH:              begin aop = 2'b01; asrc = 1'b0; end
      OP_JAL:                 begin aop = 2'b00; asrc = 1'b0; end
      default:                return n;
    endcase
    c = blank();
    c.exp.alu_op = aop;
    c.exp.alu_src = asrc;
    c.do_branch = br;
    if (op == OP_BRANCH || op == OP_JAL) begin
      c.exp.pc_write = 1'b1;
      c.exp.retire = 1'b1;
      c.exp.pc_src = (op == OP_JAL) ? 1'b1 : br;
      if (op == OP_JAL) begin
        c.exp.reg_write = 1'b1;
        c.exp.wb_sel = 2'b10;
      end
      push(c); n++; cnt++;
      return n;
    end
    push(c); n++;
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int w = 0; w <= dw; w++) begin
        c = blank();
        c.exp.alu_op = aop;
        c.exp.alu_src = asrc;
        c.dmem_ready = (w == dw);
        c.exp.dmem_req = 1'b1;
        c.exp.dmem_we = (op == OP_STORE);
        if (w == dw && op == OP_STORE) begin
          c.exp.pc_write = 1'b1;
          c.exp.retire = 1'b1;
        end
        push(c); n++;
      end
      if (op == OP_STORE) begin
        cnt++;
        return n;
      end
    end
    c = blank();
    c.exp.alu_op = aop;
    c.exp.alu_src = asrc;
    c.exp.reg_write = 1'b1;
    c.exp.wb_sel = (op == OP_LOAD) ? 2'b01 : 2'b00;
    c.exp.pc_write = 1'b1;
    c.exp.retire = 1'b1;
    push(c); n++; cnt++;
    return n;
  endfunction

  task automatic pin(string name, int act, int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic run_queue();
    cycle_t c;
    outv_t  act;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      rst = c.rst; halt = c.halt; opcode = c.opcode; do_branch = c.do_branch;
      imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
      @(negedge clk);
      act = {imem_req, ir_write, alu_op, alu_src, dmem_req, dmem_we, reg_write,
             wb_sel, pc_write, pc_src, retire, trap, instret};
      checks++;
      if (act !== c.exp) begin
        fails++;
        $display("FAIL cycle t=%0t: outputs got %b expected %b", $time, act, c.exp);
      end
    end
  endtask

  logic [6:0] ops [6];
  int         len;

  initial begin
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
    rst = 1'b0; halt = 1'b0; opcode = '0; do_branch = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;

    gen_reset();
    len = gen(OP_R, 0, 0, 0, 1'b0);      pin("lat_r", len, 4);
    pin("cnt_after_r", cnt, 1);
    len = gen(OP_LOAD, 0, 0, 2, 1'b0);   pin("lat_load_wait2", len, 7);
    len = gen(OP_STORE, 0, 0, 0, 1'b0);  pin("lat_store", len, 4);
    len = gen(OP_I, 0, 0, 0, 1'b0);      pin("lat_i", len, 4);
    len = gen(OP_BRANCH, 0, 0, 0, 1'b1); pin("lat_beq_taken", len, 3);
    len = gen(OP_BRANCH, 0, 0, 0, 1'b0); pin("lat_beq_not", len, 3);
    len = gen(OP_JAL, 0, 0, 0, 1'b0);    pin("lat_jal", len, 3);
    len = gen(OP_LOAD, 0, 0, 0, 1'b0);   pin("lat_load", len, 5);
    len = gen(OP_R, 6, 2, 0, 1'b0);      pin("lat_r_imem_wait2", len, 6);
    run_queue();

    for (int i = 0; i < 60; i++) begin
      len = gen(ops[$urandom_range(5)], $urandom_range(2), $urandom_range(3),
                $urandom_range(3), 1'($urandom));
      if (i % 10 == 9) run_queue();
    end
    run_queue();

    gen_reset();
    for (int i = 0; i < 16; i++)
      len = gen(OP_R, 0, $urandom_range(1), 0, 1'b0);
    pin("wrap_model_cnt", cnt, 16);
    len = gen(OP_I, 0, 0, 0, 1'b0);
    run_queue();

    len = gen(OP_R, 0, 0, 0, 1'b0);
    budget = 5;
    len = gen(OP_STORE, 0, 0, 10, 1'b0);
    budget = -1;
    pin("mid_store_queue", q.size(), 9);
    gen_reset();
    len = gen(OP_STORE, 0, 1, 1, 1'b0);
    run_queue();

    len = gen(OP_BAD, 0, 1, 0, 1'b0);    pin("lat_illegal", len, 3);
    gen_trap(20);
    gen_reset();
    len = gen(OP_R, 0, 0, 0, 1'b0);
    pin("cnt_after_trap_reset", cnt, 1);
    run_queue();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
